// File: rtl/uart_receiver_pkg.sv
// UART definitions shared by the receiver, transmitter and baud generator:
// FSM encodings, default oversample ratio and frame data width.
package uart_receiver_pkg;

  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int FRAME_DATA_W       = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous rx line; resets to the idle
// (high) level so a reset never looks like a start edge.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: start, 8 data bits LSB first, optional even
// parity (define PARITY_CHECK_EN), stop. One rx_valid pulse per frame.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int OVERSAMPLE  = DEFAULT_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  input  logic       inrx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_MID = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_END = TICK_W'(OVERSAMPLE - 1);

  uart_state_t             state;
  uart_state_t             state_nxt;
  logic                    rx_sync;
  logic                    rx_prev;
  logic                    start_edge;
  logic [TICK_W-1:0]       tick_cnt;
  logic [2:0]              bit_cnt;
  logic [FRAME_DATA_W-1:0] rx_shift;
  logic                    stop_sample;
  logic                    done_pend;

  logic tick_clr;
  logic tick_inc;
  logic bit_clr;
  logic shift_en;
  logic stop_en;

  uart_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_in),
    .q     (rx_sync)
  );

  // rx_prev only follows the line at ticks, so a line held low cannot retrigger
  assign start_edge = inrx & rx_prev & ~rx_sync;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

`ifdef PARITY_CHECK_EN
  logic par_en;
  logic par_sample;
`endif

  always_comb begin
    state_nxt = state;
    tick_clr  = 1'b0;
    tick_inc  = 1'b0;
    bit_clr   = 1'b0;
    shift_en  = 1'b0;
    stop_en   = 1'b0;
`ifdef PARITY_CHECK_EN
    par_en    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start_edge) begin
          state_nxt = START;
          tick_clr  = 1'b1;
          bit_clr   = 1'b1;
        end
      end
      START: begin
        if (inrx) begin
          if (tick_cnt == TICK_MID) begin
            tick_clr  = 1'b1;
            state_nxt = rx_sync ? IDLE : DATA;
          end else begin
            tick_inc = 1'b1;
          end
        end
      end
      DATA: begin
        if (inrx) begin
          if (tick_cnt == TICK_END) begin
            tick_clr = 1'b1;
            shift_en = 1'b1;
            if (bit_cnt == 3'd7) begin
`ifdef PARITY_CHECK_EN
              state_nxt = PARITY;
`else
              state_nxt = STOP;
`endif
            end
          end else begin
            tick_inc = 1'b1;
          end
        end
      end
`ifdef PARITY_CHECK_EN
      PARITY: begin
        if (inrx) begin
          if (tick_cnt == TICK_END) begin
            tick_clr  = 1'b1;
            par_en    = 1'b1;
            state_nxt = STOP;
          end else begin
            tick_inc = 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (inrx) begin
          if (tick_cnt == TICK_END) begin
            tick_clr  = 1'b1;
            stop_en   = 1'b1;
            state_nxt = IDLE;
          end else begin
            tick_inc = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_prev     <= 1'b1;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      stop_sample <= 1'b1;
    end else begin
      if (inrx) begin
        rx_prev <= rx_sync;
      end
      if (tick_clr) begin
        tick_cnt <= '0;
      end else if (tick_inc) begin
        tick_cnt <= tick_cnt + 1'b1;
      end
      if (bit_clr) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (shift_en) begin
        rx_shift <= {rx_sync, rx_shift[FRAME_DATA_W-1:1]};
      end
      if (stop_en) begin
        stop_sample <= rx_sync;
      end
    end
  end

  // Result stage: publish one clk after the stop-bit tick, independent of inrx
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_pend <= 1'b0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      frame_err <= 1'b0;
    end else begin
      done_pend <= stop_en;
      rx_valid  <= done_pend;
      if (done_pend) begin
        rx_data   <= rx_shift;
        frame_err <= ~stop_sample;
      end
    end
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_sample <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (par_en) begin
        par_sample <= rx_sync;
      end
      if (done_pend) begin
        parity_err <= par_sample ^ (^rx_shift);
      end
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
